// File: rtl/wishbone_master_ctrl_if.sv
// Bus bundle for wishbone_master_ctrl: the local command/response handshake
// plus the Wishbone classic initiator signals. The master modport is the
// controller's view; the slave modport is the view of whatever drives
// commands and models the responder.
interface wishbone_master_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_we_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [DATA_W-1:0] cmd_data_i;

  logic              rsp_valid_o;
  logic [DATA_W-1:0] rsp_data_o;
  logic              rsp_err_o;

  logic [ADDR_W-1:0] addr_o;
  logic              we_o;
  logic [DATA_W-1:0] data_o;
  logic              cyc_o;
  logic              stb_o;
  logic [DATA_W-1:0] data_i;
  logic              ack_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_data_i, data_i, ack_i,
    output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
           addr_o, we_o, data_o, cyc_o, stb_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_data_i, data_i, ack_i,
    input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
           addr_o, we_o, data_o, cyc_o, stb_o
  );

endinterface

// File: rtl/wishbone_master_ctrl.sv
// Wishbone classic single-transfer initiator. One command in, one CYC/STB
// cycle out, one response back. After the ack the controller parks in
// RELEASE until the responder drops ack_i, so a held ACK can never be
// mistaken for the acknowledge of the following transfer.
// Optional build macro WB_MASTER_TIMEOUT_EN adds a BUSY watchdog that aborts
// the cycle with rsp_err_o after TIMEOUT_CYCLES cycles without ack_i.
module wishbone_master_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                  clk_i,
  input logic                  rst_i,
  wishbone_master_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cyc_q, cyc_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Next-state and next-output decode; every registered output is computed here
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    cyc_d       = cyc_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
`ifdef WB_MASTER_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        cyc_d = 1'b0;
        if (bus.cmd_valid_i) begin
          addr_d  = bus.cmd_addr_i;
          we_d    = bus.cmd_we_i;
          wdata_d = bus.cmd_we_i ? bus.cmd_data_i : '0;
          cyc_d   = 1'b1;
          state_d = BUSY;
`ifdef WB_MASTER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      BUSY: begin
        if (bus.ack_i) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = we_q ? '0 : bus.data_i;
          state_d     = RELEASE;
`ifdef WB_MASTER_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
          cnt_d       = cnt_q + CNT_W'(1);
          state_d     = RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end

      RELEASE: begin
        cyc_d = 1'b0;
        if (!bus.ack_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        cyc_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      cyc_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      cyc_q       <= cyc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef WB_MASTER_TIMEOUT_EN
  // Watchdog counter of ack-less BUSY cycles
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign bus.cmd_ready_o = ready_q;
  assign bus.addr_o      = addr_q;
  assign bus.we_o        = we_q;
  assign bus.data_o      = wdata_q;
  assign bus.cyc_o       = cyc_q;
  assign bus.stb_o       = cyc_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_data_o  = rsp_data_q;
  assign bus.rsp_err_o   = rsp_err_q;

endmodule
